lap_timer: RTL and testbench

//  Parametrised stopwatch with lap memory: BCD time counter (centiseconds,

---
 rtl/lap_timer_pkg.sv | 38 +++
 rtl/lap_timer_if.sv | 29 ++
 rtl/lap_timer_bcd_digit_cnt.sv | 39 +++
 rtl/lap_timer.sv | 141 ++++++++++++++
 tb/tb_lap_timer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap_timer stopwatch.
// Optional feature macro: LAP_TIMER_MINUTES_EN adds a minutes field (NDIG=6).
package lap_timer_pkg;

`ifdef LAP_TIMER_MINUTES_EN
  localparam int NDIG = 6;
`else
  localparam int NDIG = 4;
`endif

  // Largest value of a units digit and of a tens digit for seconds/minutes
  localparam int UNITS_MAX = 9;
  localparam int TENS_MAX  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // One nibble per BCD digit; centisecond units in the least significant nibble
  typedef struct packed {
`ifdef LAP_TIMER_MINUTES_EN
    logic [3:0] m_t;
    logic [3:0] m_u;
`endif
    logic [3:0] s_t;
    logic [3:0] s_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } bcd_time_t;

  // Digit positions 3 (seconds tens) and 5 (minutes tens) roll over after 5
  function automatic int digit_max(input int pos);
    return ((pos == 3) || (pos == 5)) ? TENS_MAX : UNITS_MAX;
  endfunction

endpackage

// File: rtl/lap_timer_if.sv
// Control/display bundle between the board logic and the lap_timer core.
// Width of disp_bcd follows NDIG (set by LAP_TIMER_MINUTES_EN).
interface lap_timer_if
  import lap_timer_pkg::*;
#(
  parameter int LAPS = 3
);
  localparam int LAP_IDX_W = $clog2(LAPS);

  logic                   start_stop;
  logic                   lap;
  logic                   clear;
  logic                   recall_en;
  logic [LAP_IDX_W-1:0]   recall_idx;
  logic [4*NDIG-1:0]      disp_bcd;
  logic                   disp_valid;
  logic                   running;
  logic [LAP_IDX_W:0]     lap_count;

  modport master (
    output start_stop, lap, clear, recall_en, recall_idx,
    input  disp_bcd, disp_valid, running, lap_count
  );

  modport slave (
    input  start_stop, lap, clear, recall_en, recall_idx,
    output disp_bcd, disp_valid, running, lap_count
  );
endinterface

// File: rtl/lap_timer_bcd_digit_cnt.sv
// Single BCD digit counter: counts 0..MAX on en, carry when wrapping.
module lap_timer_bcd_digit_cnt #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);
  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] q_q, q_d;

  assign carry = en && (q_q == MAX_V);
  assign q     = q_q;

  // Next digit value: clear dominates, wrap on carry, else step on enable
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (carry) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end
endmodule

// File: rtl/lap_timer.sv
// Stopwatch core: prescaled BCD time, IDLE/RUN/STOP control, circular lap
// buffer with recall. LAP_TIMER_MINUTES_EN enables the minutes field.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int LAPS    = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  lap_timer_if.slave  bus
);
  localparam int LAP_IDX_W = $clog2(LAPS);
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int PRESC_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [LAP_IDX_W-1:0] PTR_LAST   = LAP_IDX_W'(LAPS - 1);
  localparam logic [LAP_IDX_W:0]   COUNT_FULL = (LAP_IDX_W + 1)'(LAPS);

  state_e                 state_q, state_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [LAP_IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LAP_IDX_W:0]     lap_count_q, lap_count_d;
  bcd_time_t              disp_q, disp_d;
  logic                   disp_valid_q, disp_valid_d;
  logic                   running_q, running_d;

  logic                   tick;
  logic                   time_clr;
  logic                   lap_we;
  logic                   recall_hit;
  logic [4*NDIG-1:0]      time_bits;
  logic [NDIG-1:0]        dig_en;
  logic [NDIG-1:0]        dig_carry;
  logic                   time_wrap_unused;
  bcd_time_t              time_now;
  bcd_time_t              lap_mem [LAPS];

  // Control decode and next state; clear only takes effect outside RUN
  always_comb begin
    state_d  = state_q;
    tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    time_clr = bus.clear && (state_q != RUN);
    lap_we   = bus.lap && ((state_q == RUN) || ((state_q == STOP) && !bus.clear));
    unique case (state_q)
      IDLE: if (bus.start_stop) state_d = RUN;
      RUN:  if (bus.start_stop) state_d = STOP;
      STOP: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else if (bus.start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Time digits: tick enables the LSB digit, each carry enables the next one
  assign dig_en = {dig_carry[NDIG-2:0], tick};
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    lap_timer_bcd_digit_cnt #(
      .MAX (digit_max(gi))
    ) u_digit (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .en    (dig_en[gi]),
      .clr   (time_clr),
      .q     (time_bits[4*gi +: 4]),
      .carry (dig_carry[gi])
    );
  end
  // Final carry marks the silent wrap of the top field; nothing consumes it
  assign time_wrap_unused = dig_carry[NDIG-1];
  assign time_now         = time_bits;

  // Prescaler, lap pointer/count and display next values
  always_comb begin
    presc_d     = '0;
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    running_d   = (state_q == RUN);
    recall_hit  = ({1'b0, bus.recall_idx} < lap_count_q);
    disp_d      = time_now;
    disp_valid_d = 1'b1;

    // Held at zero outside RUN so the first tick lands DIV cycles after start
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (time_clr) begin
      wr_ptr_d    = '0;
      lap_count_d = '0;
    end else if (lap_we) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (lap_count_q != COUNT_FULL) begin
        lap_count_d = lap_count_q + 1'b1;
      end
    end

    if (bus.recall_en) begin
      disp_d       = recall_hit ? lap_mem[bus.recall_idx] : '0;
      disp_valid_d = recall_hit;
    end
  end

  // Lap memory write port; contents are meaningful only below lap_count
  always_ff @(posedge CLOCK_50) begin
    if (lap_we) begin
      lap_mem[wr_ptr_q] <= time_now;
    end
  end

  // State, prescaler, lap bookkeeping and registered display outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      wr_ptr_q     <= '0;
      lap_count_q  <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      wr_ptr_q     <= wr_ptr_d;
      lap_count_q  <= lap_count_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      running_q    <= running_d;
    end
  end

  assign bus.disp_bcd   = disp_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.running    = running_q;
  assign bus.lap_count  = lap_count_q;
endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: directed scenarios plus random pulses, every cycle
// compared with a centisecond-count reference model.
module tb_lap_timer;
`ifdef LAP_TIMER_MINUTES_EN
  localparam int WRAP = 360000;
  localparam logic [31:0] WRAP_SHOW = 32'h0001_0000;
`else
  localparam int WRAP = 6000;
  localparam logic [31:0] WRAP_SHOW = 32'h0000_0000;
`endif
  localparam int LAPS_TB = 3;
  localparam int DIV     = 10;
  localparam int BUDGET  = 70000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lap_timer_if #(.LAPS(LAPS_TB)) bus();

  lap_timer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .LAPS    (LAPS_TB)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: state 0=idle 1=run 2=stop, time as plain centiseconds
  int st, base_cs, run_cyc;
  int lap_hist[$];
  int rec_en, rec_idx;
  logic [31:0] exp_disp, exp_valid, exp_run, exp_cnt;

  function automatic int cur_cs();
    return (base_cs + run_cyc / DIV) % WRAP;
  endfunction

  function automatic logic [31:0] to_bcd(input int cs);
    int c, s, m;
    logic [31:0] r;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = (cs / 6000) % 60;
    r = '0;
    r[3:0]   = 4'(c % 10);
    r[7:4]   = 4'(c / 10);
    r[11:8]  = 4'(s % 10);
    r[15:12] = 4'(s / 10);
    r[19:16] = 4'(m % 10);
    r[23:20] = 4'(m / 10);
    return r;
  endfunction

  function automatic int lap_cnt();
    return (lap_hist.size() < LAPS_TB) ? lap_hist.size() : LAPS_TB;
  endfunction

  // Newest lap whose sequence number maps onto slot i
  function automatic int slot_val(input int i);
    for (int k = lap_hist.size() - 1; k >= 0; k--) begin
      if (k % LAPS_TB == i) return lap_hist[k];
    end
    return 0;
  endfunction

  task automatic model_reset();
    st = 0; base_cs = 0; run_cyc = 0;
    lap_hist.delete();
    exp_disp = '0; exp_valid = 1; exp_run = 0; exp_cnt = 0;
  endtask

  task automatic model_clear();
    base_cs = 0; run_cyc = 0;
    lap_hist.delete();
  endtask

  // One clock edge of the model; display reflects the view before the edge
  task automatic model_edge(input bit ss, input bit lp, input bit clr);
    exp_run = (st == 1) ? 1 : 0;
    if (rec_en == 0) begin
      exp_disp = to_bcd(cur_cs()); exp_valid = 1;
    end else if (rec_idx < lap_cnt()) begin
      exp_disp = to_bcd(slot_val(rec_idx)); exp_valid = 1;
    end else begin
      exp_disp = '0; exp_valid = 0;
    end
    if (lp && ((st == 1) || (st == 2 && !clr))) lap_hist.push_back(cur_cs());
    case (st)
      0: begin
        if (clr) model_clear();
        if (ss) begin st = 1; run_cyc = 0; end
      end
      1: begin
        run_cyc++;
        if (ss) begin
          base_cs = cur_cs(); run_cyc = 0; st = 2;
        end
      end
      default: begin
        if (clr) begin model_clear(); st = 0; end
        else if (ss) begin st = 1; run_cyc = 0; end
      end
    endcase
    exp_cnt = lap_cnt();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed checkpoint against a value fixed by the scenario itself
  task automatic txn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    $display("txn %s observed=%0h expected=%0h", tag, obs, exp);
    check(tag, obs, exp);
  endtask

  task automatic set_recall(input int en, input int idx);
    rec_en = en; rec_idx = idx;
    bus.recall_en  = 1'(en);
    bus.recall_idx = 2'(idx);
  endtask

  task automatic step(input bit ss = 0, input bit lp = 0, input bit clr = 0);
    bus.start_stop = ss; bus.lap = lp; bus.clear = clr;
    @(posedge clk);
    model_edge(ss, lp, clr);
    #1;
    bus.start_stop = 1'b0; bus.lap = 1'b0; bus.clear = 1'b0;
    check("disp", 32'(bus.disp_bcd), exp_disp);
    check("valid", 32'(bus.disp_valid), exp_valid);
    check("running", 32'(bus.running), exp_run);
    check("lap_count", 32'(bus.lap_count), exp_cnt);
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (cur_cs() != target && n < BUDGET) begin
      step();
      n++;
    end
    checks++;
    assert (n < BUDGET) else begin
      failures++;
      $error("FAIL run_until observed=%0d expected=%0d", cur_cs(), target);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_stop = 1'b0; bus.lap = 1'b0; bus.clear = 1'b0;
    set_recall(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn("reset_disp", 32'(bus.disp_bcd), 32'h0);
    txn("reset_valid", 32'(bus.disp_valid), 32'h1);
    txn("reset_running", 32'(bus.running), 32'h0);
    txn("reset_count", 32'(bus.lap_count), 32'h0);

    // 1: one second of running
    step(1);
    repeat (1001) step();
    txn("t1_disp", 32'(bus.disp_bcd), 32'h0100);
    txn("t1_running", 32'(bus.running), 32'h1);

    // 2: top-field wrap
    run_until(5999);
    step();
    txn("t2_disp_5999", 32'(bus.disp_bcd), 32'h5999);
    for (int n = 0; n < 2 * DIV && cur_cs() == 5999; n++) step();
    step();
    txn("t2_wrap", 32'(bus.disp_bcd), WRAP_SHOW);
    step(1);
    step(0, 0, 1);
    txn("t2_cleared_count", 32'(bus.lap_count), 32'h0);

    // 3: four laps into three slots
    step(1);
    run_until(25);  step(0, 1);
    run_until(50);  step(0, 1);
    run_until(75);  step(0, 1);
    run_until(100); step(0, 1);
    txn("t3_count", 32'(bus.lap_count), 32'h3);
    set_recall(1, 0); step();
    txn("t3_slot0", 32'(bus.disp_bcd), 32'h0100);
    set_recall(1, 1); step();
    txn("t3_slot1", 32'(bus.disp_bcd), 32'h0050);
    txn("t3_slot1_valid", 32'(bus.disp_valid), 32'h1);
    set_recall(1, 2); step();
    txn("t3_slot2", 32'(bus.disp_bcd), 32'h0075);
    set_recall(1, 3); step();
    txn("t3_idx3_valid", 32'(bus.disp_valid), 32'h0);
    txn("t3_idx3_disp", 32'(bus.disp_bcd), 32'h0);
    txn("t3_recall_running", 32'(bus.running), 32'h1);

    // 4: stop at 02.00, recall, then clear
    set_recall(0, 0);
    run_until(200);
    step(1);
    step();
    txn("t4_stopped", 32'(bus.running), 32'h0);
    repeat (20) step();
    txn("t4_frozen", 32'(bus.disp_bcd), 32'h0200);
    set_recall(1, 1); step();
    txn("t4_recall1", 32'(bus.disp_bcd), 32'h0050);
    txn("t4_recall1_valid", 32'(bus.disp_valid), 32'h1);
    step(0, 0, 1);
    step();
    txn("t4_clr_disp", 32'(bus.disp_bcd), 32'h0);
    txn("t4_clr_valid", 32'(bus.disp_valid), 32'h0);
    txn("t4_clr_count", 32'(bus.lap_count), 32'h0);

    // 5: lap and stop in the same cycle
    set_recall(0, 0);
    step(1);
    run_until(30);
    step(1, 1);
    step();
    txn("t5_running", 32'(bus.running), 32'h0);
    txn("t5_count", 32'(bus.lap_count), 32'h1);
    repeat (50) step();
    txn("t5_frozen", 32'(bus.disp_bcd), 32'h0030);
    set_recall(1, 0); step();
    txn("t5_slot0", 32'(bus.disp_bcd), 32'h0030);
    step(0, 1, 1);
    txn("t5_clear_beats_lap", 32'(bus.lap_count), 32'h0);
    step(0, 1);
    txn("t5_lap_in_idle", 32'(bus.lap_count), 32'h0);
    set_recall(0, 0);
    step(1);
    run_until(10);
    step(0, 0, 1);
    step();
    txn("t5_clear_in_run", 32'(bus.running), 32'h1);

    // 6: asynchronous reset mid-run
    run_until(40);
    step(0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    txn("t6_disp", 32'(bus.disp_bcd), 32'h0);
    txn("t6_running", 32'(bus.running), 32'h0);
    txn("t6_count", 32'(bus.lap_count), 32'h0);
    txn("t6_valid", 32'(bus.disp_valid), 32'h1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random pulses and recall selections against the model
    for (int i = 0; i < 3000; i++) begin
      bit ss, lp, clr;
      ss  = ($urandom_range(0, 39) == 0);
      lp  = ($urandom_range(0, 14) == 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) set_recall(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      step(ss, lp, clr);
    end
    $display("txn random_phase done laps_held=%0d", lap_cnt());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
